// File: rtl/warships_pkg.sv
// warships_pkg
// Shared types for the board click controller:
//   cell_state_t - 2-bit state stored per grid cell
//   board_op_t   - per-board click operation (PLACE / SHOOT)
//   ctl_state_t  - controller FSM state; ST_CLEAR exists only when
//                  BOARD_CLEAR_EN is defined
//   next_cell()  - cell transition for a click; returns the input state
//                  unchanged when the click must not write
package warships_pkg;

  typedef enum logic [1:0] {
    CELL_EMPTY = 2'd0,
    CELL_SHIP  = 2'd1,
    CELL_MISS  = 2'd2,
    CELL_HIT   = 2'd3
  } cell_state_t;

  typedef enum logic {
    OP_PLACE = 1'b0,
    OP_SHOOT = 1'b1
  } board_op_t;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOCATE = 3'd1,
    ST_READ   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_WRITE  = 3'd4
`ifdef BOARD_CLEAR_EN
    ,
    ST_CLEAR  = 3'd5
`endif
  } ctl_state_t;

  // MISS and HIT are terminal: a click on them leaves the cell as is.
  function automatic cell_state_t next_cell(input board_op_t op, input cell_state_t cur);
    cell_state_t nxt;
    nxt = cur;
    case (cur)
      CELL_EMPTY: nxt = (op == OP_SHOOT) ? CELL_MISS : CELL_SHIP;
      CELL_SHIP:  nxt = (op == OP_SHOOT) ? CELL_HIT : CELL_EMPTY;
      default:    nxt = cur;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/click_sync.sv
// click_sync
// Two-flop synchroniser for the asynchronous mouse button level plus a
// rising-edge detector on the synchronised level.
// Ports:
//   clk     - control clock
//   rst     - synchronous active-low reset (clears all flops)
//   async_i - raw button level, asynchronous to clk
//   rise_o  - one-cycle pulse on the rising edge of the synchronised level
module click_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_i,
  output logic rise_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/board_click_ctl.sv
// board_click_ctl
// Turns mouse clicks on on-screen game boards into read-modify-write
// accesses of the clicked cell in that board's memory.
// Optional feature: define BOARD_CLEAR_EN to add the clear_req input and a
// CLEAR state that writes EMPTY to every cell of every board.
// Ports:
//   clk, rst                  - clock, synchronous active-low reset
//   mouse_x_pos, mouse_y_pos  - cursor position in pixels
//   mouse_left                - left button level (asynchronous)
//   board_enable, board_op    - per-board click enable / op (0 PLACE, 1 SHOOT)
//   clear_req                 - (BOARD_CLEAR_EN only) start a full clear
//   mem_sel, mem_addr         - target board and {cell_y, cell_x}
//   mem_rd_data               - cell state, one cycle after mem_addr
//   mem_wr_en, mem_wr_data    - write strobe and new cell state
//   busy                      - FSM not idle
//   result_valid              - pulse in the write cycle of a click action
//   result_hit/board/x/y      - info on the last completed action
module board_click_ctl
  import warships_pkg::*;
#(
  parameter int N_BOARDS     = 2,
  parameter int X_SIZE       = 12,
  parameter int Y_SIZE       = 12,
  parameter int X_ADDR_WIDTH = 4,
  parameter int Y_ADDR_WIDTH = 4,
  parameter int X_POS        = 100,
  parameter int Y_POS        = 200,
  parameter int X_STRIDE     = 438,
  parameter int CELL_SIZE    = 32,
  localparam int SEL_W       = (N_BOARDS > 1) ? $clog2(N_BOARDS) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [11:0]                          mouse_x_pos,
  input  logic [11:0]                          mouse_y_pos,
  input  logic                                 mouse_left,
  input  logic [N_BOARDS-1:0]                  board_enable,
  input  logic [N_BOARDS-1:0]                  board_op,
`ifdef BOARD_CLEAR_EN
  input  logic                                 clear_req,
`endif
  output logic [SEL_W-1:0]                     mem_sel,
  output logic [Y_ADDR_WIDTH+X_ADDR_WIDTH-1:0] mem_addr,
  input  logic [1:0]                           mem_rd_data,
  output logic                                 mem_wr_en,
  output logic [1:0]                           mem_wr_data,
  output logic                                 busy,
  output logic                                 result_valid,
  output logic                                 result_hit,
  output logic [SEL_W-1:0]                     result_board,
  output logic [X_ADDR_WIDTH-1:0]              result_x,
  output logic [Y_ADDR_WIDTH-1:0]              result_y
);

  localparam int CELL_SHIFT = $clog2(CELL_SIZE);
  localparam int BOARD_W    = X_SIZE * CELL_SIZE;
  localparam int BOARD_H    = Y_SIZE * CELL_SIZE;
  localparam int AW         = Y_ADDR_WIDTH + X_ADDR_WIDTH;
  localparam int OXW        = X_ADDR_WIDTH + CELL_SHIFT;
  localparam int OYW        = Y_ADDR_WIDTH + CELL_SHIFT;

  ctl_state_t               state_q, state_d;
  logic                     click;
  logic [11:0]              x_q, y_q;
  board_op_t                op_q;
  logic [SEL_W-1:0]         sel_q;
  logic [AW-1:0]            addr_q;
  cell_state_t              wr_data_q;
  logic                     res_hit_q;
  logic [SEL_W-1:0]         res_board_q;
  logic [X_ADDR_WIDTH-1:0]  res_x_q;
  logic [Y_ADDR_WIDTH-1:0]  res_y_q;

  click_sync u_click_sync (
    .clk     (clk),
    .rst     (rst),
    .async_i (mouse_left),
    .rise_o  (click)
  );

  // ---------------- board / cell location ----------------
  // All comparisons in 32 bits so board extents past 4095 cannot wrap.
  logic [31:0]             x_ext, y_ext;
  logic                    y_in;
  logic [OYW-1:0]          off_y;
  logic [Y_ADDR_WIDTH-1:0] loc_cy;
  logic [N_BOARDS-1:0]     x_in;
  logic [X_ADDR_WIDTH-1:0] cx_arr [N_BOARDS];

  assign x_ext  = {20'd0, x_q};
  assign y_ext  = {20'd0, y_q};
  assign y_in   = (y_ext >= 32'(Y_POS)) && (y_ext < 32'(Y_POS + BOARD_H));
  assign off_y  = OYW'(y_ext - 32'(Y_POS));
  assign loc_cy = Y_ADDR_WIDTH'(off_y >> CELL_SHIFT);

  generate
    for (genvar gi = 0; gi < N_BOARDS; gi++) begin : g_board
      localparam int BX = X_POS + gi * X_STRIDE;
      logic [OXW-1:0] off_x;
      assign x_in[gi]   = (x_ext >= 32'(BX)) && (x_ext < 32'(BX + BOARD_W));
      assign off_x      = OXW'(x_ext - 32'(BX));
      assign cx_arr[gi] = X_ADDR_WIDTH'(off_x >> CELL_SHIFT);
    end
  endgenerate

  logic                    loc_hit;
  logic                    loc_en;
  board_op_t               loc_op;
  logic [SEL_W-1:0]        loc_b;
  logic [X_ADDR_WIDTH-1:0] loc_cx;

  // Boards do not overlap for sane parameters; lowest index wins otherwise.
  always_comb begin
    loc_hit = 1'b0;
    loc_en  = 1'b0;
    loc_op  = OP_PLACE;
    loc_b   = '0;
    loc_cx  = '0;
    for (int b = N_BOARDS - 1; b >= 0; b--) begin
      if (x_in[b] && y_in) begin
        loc_hit = 1'b1;
        loc_en  = board_enable[b];
        loc_op  = board_op_t'(board_op[b]);
        loc_b   = SEL_W'(b);
        loc_cx  = cx_arr[b];
      end
    end
  end

  // ---------------- cell update decision ----------------
  cell_state_t cur_cell, new_cell;
  logic        need_write;

  assign cur_cell   = cell_state_t'(mem_rd_data);
  assign new_cell   = next_cell(op_q, cur_cell);
  assign need_write = (new_cell != cur_cell);

`ifdef BOARD_CLEAR_EN
  logic [SEL_W-1:0]        clr_b_q;
  logic [Y_ADDR_WIDTH-1:0] clr_y_q;
  logic [X_ADDR_WIDTH-1:0] clr_x_q;
  logic                    clr_x_last, clr_y_last, clr_last;

  assign clr_x_last = (clr_x_q == X_ADDR_WIDTH'(X_SIZE - 1));
  assign clr_y_last = (clr_y_q == Y_ADDR_WIDTH'(Y_SIZE - 1));
  assign clr_last   = clr_x_last && clr_y_last && (clr_b_q == SEL_W'(N_BOARDS - 1));
`endif

  // ---------------- FSM next state and outputs ----------------
  always_comb begin
    state_d      = state_q;
    busy         = (state_q != ST_IDLE);
    mem_wr_en    = 1'b0;
    result_valid = 1'b0;
    mem_sel      = sel_q;
    mem_addr     = addr_q;
    mem_wr_data  = wr_data_q;
    case (state_q)
      ST_IDLE: begin
`ifdef BOARD_CLEAR_EN
        if (clear_req) begin
          state_d = ST_CLEAR;
        end else
`endif
        if (click) begin
          state_d = ST_LOCATE;
        end
      end
      ST_LOCATE: state_d = (loc_hit && loc_en) ? ST_READ : ST_IDLE;
      ST_READ:   state_d = ST_WAIT;
      ST_WAIT:   state_d = need_write ? ST_WRITE : ST_IDLE;
      ST_WRITE: begin
        mem_wr_en    = 1'b1;
        result_valid = 1'b1;
        state_d      = ST_IDLE;
      end
`ifdef BOARD_CLEAR_EN
      ST_CLEAR: begin
        mem_wr_en   = 1'b1;
        mem_sel     = clr_b_q;
        mem_addr    = {clr_y_q, clr_x_q};
        mem_wr_data = CELL_EMPTY;
        if (clr_last) begin
          state_d = ST_IDLE;
        end
      end
`endif
      default: state_d = ST_IDLE;
    endcase
  end

  // ---------------- registers ----------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      x_q         <= '0;
      y_q         <= '0;
      op_q        <= OP_PLACE;
      sel_q       <= '0;
      addr_q      <= '0;
      wr_data_q   <= CELL_EMPTY;
      res_hit_q   <= 1'b0;
      res_board_q <= '0;
      res_x_q     <= '0;
      res_y_q     <= '0;
`ifdef BOARD_CLEAR_EN
      clr_b_q     <= '0;
      clr_y_q     <= '0;
      clr_x_q     <= '0;
`endif
    end else begin
      state_q <= state_d;
      case (state_q)
        ST_IDLE: begin
          // Tracking the cursor every idle cycle leaves the position of the
          // click cycle frozen once the FSM moves on.
          x_q <= mouse_x_pos;
          y_q <= mouse_y_pos;
`ifdef BOARD_CLEAR_EN
          clr_b_q <= '0;
          clr_y_q <= '0;
          clr_x_q <= '0;
`endif
        end
        ST_LOCATE: begin
          if (loc_hit && loc_en) begin
            sel_q  <= loc_b;
            addr_q <= {loc_cy, loc_cx};
            op_q   <= loc_op;
          end
        end
        ST_WAIT: begin
          if (need_write) begin
            wr_data_q   <= new_cell;
            res_hit_q   <= (op_q == OP_SHOOT) && (cur_cell == CELL_SHIP);
            res_board_q <= sel_q;
            res_x_q     <= addr_q[X_ADDR_WIDTH-1:0];
            res_y_q     <= addr_q[AW-1:X_ADDR_WIDTH];
          end
        end
`ifdef BOARD_CLEAR_EN
        ST_CLEAR: begin
          if (clr_x_last) begin
            clr_x_q <= '0;
            if (clr_y_last) begin
              clr_y_q <= '0;
              clr_b_q <= clr_b_q + 1'b1;
            end else begin
              clr_y_q <= clr_y_q + 1'b1;
            end
          end else begin
            clr_x_q <= clr_x_q + 1'b1;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  assign result_hit   = res_hit_q;
  assign result_board = res_board_q;
  assign result_x     = res_x_q;
  assign result_y     = res_y_q;

endmodule

// File: tb/tb_board_click_ctl.sv
// Bench for board_click_ctl with default parameters. A behavioural memory
// answers reads one cycle after the address; expected writes are queued by
// the stimulus and checked by an independent negedge monitor.
`timescale 1ns/1ps
module tb_board_click_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] mouse_x_pos, mouse_y_pos;
  logic        mouse_left;
  logic [1:0]  board_enable, board_op;
`ifdef BOARD_CLEAR_EN
  logic        clear_req;
`endif
  logic [0:0]  mem_sel;
  logic [7:0]  mem_addr;
  logic [1:0]  mem_rd_data;
  logic        mem_wr_en;
  logic [1:0]  mem_wr_data;
  logic        busy, result_valid, result_hit;
  logic [0:0]  result_board;
  logic [3:0]  result_x, result_y;

  always #5 clk = ~clk;

  board_click_ctl dut (
    .clk          (clk),
    .rst          (rst),
    .mouse_x_pos  (mouse_x_pos),
    .mouse_y_pos  (mouse_y_pos),
    .mouse_left   (mouse_left),
    .board_enable (board_enable),
    .board_op     (board_op),
`ifdef BOARD_CLEAR_EN
    .clear_req    (clear_req),
`endif
    .mem_sel      (mem_sel),
    .mem_addr     (mem_addr),
    .mem_rd_data  (mem_rd_data),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data),
    .busy         (busy),
    .result_valid (result_valid),
    .result_hit   (result_hit),
    .result_board (result_board),
    .result_x     (result_x),
    .result_y     (result_y)
  );

  // ---------------- memory model ----------------
  logic [1:0] mem [0:1][0:255];
  logic       poke_en = 1'b0;
  int         poke_b, poke_a;
  logic [1:0] poke_v;

  always @(posedge clk) begin
    if (poke_en) mem[poke_b][poke_a] <= poke_v;
    else if (mem_wr_en) mem[mem_sel][mem_addr] <= mem_wr_data;
    mem_rd_data <= mem[mem_sel][mem_addr];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  typedef struct {
    int sel; int x; int y; int data; int rv;
    bit chk_res; bit chk_hit; int hit; int cyc;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;
  int n_cmp = 0;
  int n_bad = 0;
  int n_wr  = 0;

  task automatic chk(input string name, input int act, input int req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic push_wr(input int sel, input int x, input int y, input int data,
                         input int rv, input bit chk_hit, input int hit, input int at_cyc);
    exp_t e;
    e.sel = sel; e.x = x; e.y = y; e.data = data; e.rv = rv;
    e.chk_res = (rv != 0); e.chk_hit = chk_hit; e.hit = hit; e.cyc = at_cyc;
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    if (mem_wr_en) begin
      n_wr++;
      $display("write %0d: sel=%0d addr=%02h data=%0d rv=%0d cycle=%0d",
               n_wr, mem_sel, mem_addr, mem_wr_data, result_valid, cyc);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_write: got sel=%0d addr=%02h data=%0d, required no write",
                 mem_sel, mem_addr, mem_wr_data);
      end else begin
        mon_e = exp_q.pop_front();
        chk("wr_cycle", cyc, mon_e.cyc);
        chk("wr_sel", int'(mem_sel), mon_e.sel);
        chk("wr_addr", int'(mem_addr), mon_e.y * 16 + mon_e.x);
        chk("wr_data", int'(mem_wr_data), mon_e.data);
        chk("result_valid", int'(result_valid), mon_e.rv);
        if (mon_e.chk_res) begin
          chk("result_board", int'(result_board), mon_e.sel);
          chk("result_x", int'(result_x), mon_e.x);
          chk("result_y", int'(result_y), mon_e.y);
        end
        if (mon_e.chk_hit) chk("result_hit", int'(result_hit), mon_e.hit);
      end
    end else if (result_valid) begin
      n_cmp++;
      n_bad++;
      $display("FAIL stray_result_valid: got 1 without write, required 0");
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic poke(input int b, input int a, input logic [1:0] v);
    poke_b = b; poke_a = a; poke_v = v; poke_en = 1'b1;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic click_at(input int x, input int y);
    mouse_x_pos = 12'(x);
    mouse_y_pos = 12'(y);
    mouse_left  = 1'b1;
    tick(2);
    mouse_left  = 1'b0;
  endtask

  initial begin
    rst = 1'b0; mouse_left = 1'b0; mouse_x_pos = '0; mouse_y_pos = '0;
    board_enable = 2'b11; board_op = 2'b10;
`ifdef BOARD_CLEAR_EN
    clear_req = 1'b0;
`endif
    tick(3);
    chk("rst_busy", int'(busy), 0);
    chk("rst_wr_en", int'(mem_wr_en), 0);
    chk("rst_result_valid", int'(result_valid), 0);
    chk("rst_mem_addr", int'(mem_addr), 0);
    chk("rst_result_x", int'(result_x), 0);
    rst = 1'b1;
    tick(2);

    // Board 0 PLACE on EMPTY at (201,265): cell x3 y2 -> SHIP
    poke(0, 8'h23, 2'd0);
    push_wr(0, 3, 2, 1, 1, 1'b0, 0, cyc + 6);
    click_at(201, 265);
    tick(8);
    chk("mem_b0_23_ship", int'(mem[0][8'h23]), 1);

    // Board 1 SHOOT on SHIP at (921,200): cell x11 y0 -> HIT
    poke(1, 8'h0B, 2'd1);
    push_wr(1, 11, 0, 3, 1, 1'b1, 1, cyc + 6);
    click_at(921, 200);
    tick(8);
    chk("held_result_hit", int'(result_hit), 1);
    chk("held_result_x", int'(result_x), 11);

    // Board 0 PLACE on SHIP -> EMPTY
    push_wr(0, 3, 2, 0, 1, 1'b0, 0, cyc + 6);
    click_at(201, 265);
    tick(8);

    // One pixel right of board 0: no access, busy for one cycle only
    click_at(484, 250);
    tick(1);
    chk("miss_busy_locate", int'(busy), 1);
    tick(1);
    chk("miss_busy_idle", int'(busy), 0);
    tick(6);

    // Board 1 disabled
    board_enable = 2'b01;
    click_at(600, 300);
    tick(1);
    chk("dis_busy_locate", int'(busy), 1);
    tick(1);
    chk("dis_busy_idle", int'(busy), 0);
    tick(6);
    board_enable = 2'b11;

    // Double click while busy: only the first SHOOT (EMPTY->MISS) at x0 y1
    board_op = 2'b11;
    poke(0, 8'h10, 2'd0);
    push_wr(0, 0, 1, 2, 1, 1'b1, 0, cyc + 6);
    mouse_x_pos = 12'd130; mouse_y_pos = 12'd240;
    mouse_left = 1'b1; tick(1);
    mouse_left = 1'b0; tick(1);
    mouse_left = 1'b1; tick(1);
    mouse_left = 1'b0; tick(10);

    // SHOOT on MISS: no write, back to idle after WAIT
    click_at(130, 240);
    tick(3);
    chk("miss_cell_busy_wait", int'(busy), 1);
    tick(1);
    chk("miss_cell_busy_idle", int'(busy), 0);
    tick(6);

    // Board 1 corners: bottom-right SHOOT on EMPTY, top-left SHOOT on SHIP
    poke(1, 8'hBB, 2'd0);
    push_wr(1, 11, 11, 2, 1, 1'b1, 0, cyc + 6);
    click_at(921, 583);
    tick(8);
    poke(1, 8'h00, 2'd1);
    push_wr(1, 0, 0, 3, 1, 1'b1, 1, cyc + 6);
    click_at(538, 200);
    tick(8);
    click_at(537, 200);
    tick(8);

    // op/enable changed after LOCATE must not affect the action
    board_op = 2'b10;
    poke(0, 8'h00, 2'd0);
    push_wr(0, 0, 0, 1, 1, 1'b0, 0, cyc + 6);
    click_at(100, 200);
    tick(2);
    board_op = 2'b11; board_enable = 2'b10;
    tick(6);
    board_op = 2'b10; board_enable = 2'b11;
    chk("mem_b0_00_ship", int'(mem[0][8'h00]), 1);

    // Reset during WAIT aborts the write and clears all outputs
    poke(0, 8'h45, 2'd1);
    click_at(261, 329);
    tick(3);
    chk("wait_busy", int'(busy), 1);
    rst = 1'b0;
    tick(1);
    chk("abort_busy", int'(busy), 0);
    chk("abort_wr_en", int'(mem_wr_en), 0);
    chk("abort_result_valid", int'(result_valid), 0);
    chk("abort_result_hit", int'(result_hit), 0);
    chk("abort_result_board", int'(result_board), 0);
    chk("abort_result_x", int'(result_x), 0);
    chk("abort_result_y", int'(result_y), 0);
    chk("abort_mem_sel", int'(mem_sel), 0);
    chk("abort_mem_addr", int'(mem_addr), 0);
    chk("abort_wr_data", int'(mem_wr_data), 0);
    rst = 1'b1;
    tick(8);
    chk("mem_b0_45_kept", int'(mem[0][8'h45]), 1);

`ifdef BOARD_CLEAR_EN
    begin
      int k;
      int i;
      k = cyc;
      i = 0;
      for (int b = 0; b < 2; b++)
        for (int y = 0; y < 12; y++)
          for (int x = 0; x < 12; x++) begin
            i++;
            push_wr(b, x, y, 0, 0, 1'b0, 0, k + i);
          end
      clear_req = 1'b1;
      mouse_x_pos = 12'd201; mouse_y_pos = 12'd265; mouse_left = 1'b1;
      tick(1);
      clear_req = 1'b0;
      mouse_left = 1'b0;
      tick(288);
      chk("clear_done_busy", int'(busy), 0);
      tick(8);
      chk("clear_b0_23", int'(mem[0][8'h23]), 0);
    end
`endif

    tick(4);
    chk("pending_expectations", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
